// File: rtl/serial_or_nibble.sv
// Bit-serial 4-bit bitwise-logic engine with valid/ready on both sides (OR by default).
// Define LOGIC_OP_SEL_EN to add the 2-bit `op` port: 00=OR, 01=AND, 10=XOR, 11=NOR.
module serial_or_nibble (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] y,
    output logic       busy
`ifdef LOGIC_OP_SEL_EN
    ,
    input  logic [1:0] op
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] a_sh_q, a_sh_d;
    logic [3:0] b_sh_q, b_sh_d;
    logic [3:0] y_sh_q, y_sh_d;
    logic [3:0] y_q, y_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] op_sel;

`ifdef LOGIC_OP_SEL_EN
    logic [1:0] op_q, op_d;
    assign op_sel = op_q;
`else
    assign op_sel = 2'b00;
`endif

    function automatic logic bit_fn(input logic [1:0] f, input logic x, input logic z);
        case (f)
            2'b00:   bit_fn = x | z;
            2'b01:   bit_fn = x & z;
            2'b10:   bit_fn = x ^ z;
            default: bit_fn = ~(x | z);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        y_sh_d  = y_sh_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
`ifdef LOGIC_OP_SEL_EN
        op_d    = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    y_sh_d  = 4'h0;
                    cnt_d   = 2'd0;
`ifdef LOGIC_OP_SEL_EN
                    op_d    = op;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // LSB-first: each result bit enters at the MSB and walks down to bit 0.
                y_sh_d = {bit_fn(op_sel, a_sh_q[0], b_sh_q[0]), y_sh_q[3:1]};
                a_sh_d = {1'b0, a_sh_q[3:1]};
                b_sh_d = {1'b0, b_sh_q[3:1]};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    y_d     = y_sh_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= 4'h0;
            b_sh_q  <= 4'h0;
            y_sh_q  <= 4'h0;
            y_q     <= 4'h0;
            cnt_q   <= 2'd0;
`ifdef LOGIC_OP_SEL_EN
            op_q    <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            y_sh_q  <= y_sh_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
`ifdef LOGIC_OP_SEL_EN
            op_q    <= op_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

endmodule
